// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared FSM encodings and tag-width helper for the FIFO write arbiter.
package fifo_wr_arbiter_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick: combinational round-robin picker, scanning rr_ptr+1 .. rr_ptr+N_REQ.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = tag_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   rr_ptr_i,
    output logic [IDW-1:0]   pick_o,
    output logic             any_o
);
    always_comb begin
        int idx;
        pick_o = '0;
        any_o  = 1'b0;
        // Descending scan so the nearest requester after rr_ptr is assigned last and wins.
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_i) + k) % N_REQ;
            if (req_i[idx]) begin
                pick_o = IDW'(idx);
                any_o  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port, words tagged {source, payload}.
// Optional burst ownership (BURST_LEN beats per owner) enabled by FIFO_ARB_BURST_EN.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DW-1:0]           req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          full,
    output logic                          wEn,
    output logic [DW+tag_w(N_REQ)-1:0]    wData,
    output logic [tag_w(N_REQ)-1:0]       grant_id
);
    localparam int IDW = tag_w(N_REQ);

    if (N_REQ < 2 || BURST_LEN < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: N_REQ must be >=2 and BURST_LEN >=1");
    end

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick;
    logic [N_REQ-1:0] eligible;
    logic             any_valid, accept;

    fifo_wr_arbiter_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
        .req_i   (eligible),
        .rr_ptr_i(rr_ptr_q),
        .pick_o  (pick),
        .any_o   (any_valid)
    );

    assign req_ready = (any_valid && !full && !rst) ? (N_REQ'(1) << pick) : '0;
    assign accept    = |(req_valid & req_ready);
    assign wEn       = accept;
    assign wData     = {pick, req_data[int'(pick)*DW +: DW]};
    assign grant_id  = grant_id_q;
    assign rr_ptr_d   = accept ? pick : rr_ptr_q;
    assign grant_id_d = accept ? pick : grant_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= IDW'(N_REQ - 1);
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int BCW = $clog2(BURST_LEN + 1);

    arb_state_e     state_q, state_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0] owner_q, owner_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            beat_cnt_q <= '0;
            owner_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            owner_q    <= owner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        owner_d    = owner_q;
        if (state_q == ARB_IDLE) begin
            if (accept) begin
                state_d    = (BURST_LEN == 1) ? ARB_IDLE : ARB_LOCK;
                beat_cnt_d = (BURST_LEN == 1) ? '0 : BCW'(1);
                owner_d    = pick;
            end
        end else if (!full) begin
            // An idle owner or a finished burst both release the lock at this edge.
            if (!req_valid[owner_q] || beat_cnt_q + BCW'(1) == BCW'(BURST_LEN)) begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end
    end

    always_comb begin
        eligible = req_valid;
        if (state_q == ARB_LOCK) eligible = req_valid & (N_REQ'(1) << owner_q);
    end
`else
    always_comb begin
        eligible = req_valid;
    end
`endif
endmodule
